// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between two FWFT FIFOs.
// One byte per grant cycle: pop + tx_start together, then wait for the done tick.
module uart_tx_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  empty0,
    input  logic [DATA_WIDTH-1:0] r_data0,
    output logic                  rd0,
    input  logic                  empty1,
    input  logic [DATA_WIDTH-1:0] r_data1,
    output logic                  rd1,
    input  logic                  tx_done_tick,
    output logic                  tx_start,
    output logic [DATA_WIDTH-1:0] tx_din,
    output logic                  grant,
    output logic                  busy
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t           state_reg;
    logic             grant_reg;
    logic             last_reg;
    logic [CNT_W-1:0] burst_cnt_reg;

    logic req0;
    logic req1;
    logic req_own;
    logic req_other;
    logic burst_full;

    assign req0       = ~empty0;
    assign req1       = ~empty1;
    assign req_own    = grant_reg ? req1 : req0;
    assign req_other  = grant_reg ? req0 : req1;
    assign burst_full = (burst_cnt_reg == BURST_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            grant_reg     <= 1'b0;
            last_reg      <= 1'b1;
            burst_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (en && (req0 || req1)) begin
                        // On a tie the channel not served last wins.
                        grant_reg     <= (req0 && req1) ? ~last_reg : req1;
                        burst_cnt_reg <= '0;
                        state_reg     <= SEND;
                    end
                end
                SEND: begin
                    last_reg <= grant_reg;
                    // Saturates so a lone requester can stream indefinitely.
                    if (!burst_full) begin
                        burst_cnt_reg <= burst_cnt_reg + CNT_ONE;
                    end
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (tx_done_tick) begin
                        if (!en) begin
                            state_reg <= IDLE;
                        end else if (req_other && (!req_own || burst_full)) begin
                            grant_reg     <= ~grant_reg;
                            burst_cnt_reg <= '0;
                            state_reg     <= SEND;
                        end else if (req_own) begin
                            state_reg <= SEND;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign tx_start = (state_reg == SEND);
    assign rd0      = tx_start & ~grant_reg;
    assign rd1      = tx_start &  grant_reg;
    assign tx_din   = grant_reg ? r_data1 : r_data0;
    assign grant    = grant_reg;
    assign busy     = (state_reg == SEND) || (state_reg == WAIT);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: instance 0 uses BURST_LEN=4, instance 1 uses BURST_LEN=1,
// both fed by simple FIFO models and a transmitter model with a 10-cycle frame.
module tb_uart_tx_arbiter;

    localparam int DLY = 10;
    localparam int LOGN = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;

    logic       en_v       [2];
    logic       empty0_v   [2];
    logic       empty1_v   [2];
    logic [7:0] r_data0_v  [2];
    logic [7:0] r_data1_v  [2];
    logic       rd0_v      [2];
    logic       rd1_v      [2];
    logic       tx_done_v  [2];
    logic       tx_start_v [2];
    logic [7:0] tx_din_v   [2];
    logic       grant_v    [2];
    logic       busy_v     [2];
    logic       stray_v    [2];

    logic [7:0] mem0 [2][16];
    logic [7:0] mem1 [2][16];
    int         n0 [2];
    int         n1 [2];
    int         p0 [2];
    int         p1 [2];
    int         tmr [2];
    logic       fifo_clr = 1'b0;

    logic [7:0] log_din   [2][LOGN];
    logic       log_grant [2][LOGN];
    logic       log_rd0   [2][LOGN];
    logic       log_rd1   [2][LOGN];
    int         log_gap   [2][LOGN];
    int         log_cyc   [2][LOGN];
    int         log_n     [2];
    int         last_done [2];

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_a [9] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'hA0, 8'hA1, 8'hA2, 8'h04, 8'h05};
    logic       exp_ga[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] exp_b [8] = '{8'h00, 8'hA0, 8'h01, 8'hA1, 8'h02, 8'hA2, 8'h03, 8'hA3};

    always #5 clk = ~clk;

    uart_tx_arbiter #(.DATA_WIDTH(8), .BURST_LEN(4)) dut_a (
        .clk(clk), .reset(reset), .en(en_v[0]),
        .empty0(empty0_v[0]), .r_data0(r_data0_v[0]), .rd0(rd0_v[0]),
        .empty1(empty1_v[0]), .r_data1(r_data1_v[0]), .rd1(rd1_v[0]),
        .tx_done_tick(tx_done_v[0]), .tx_start(tx_start_v[0]), .tx_din(tx_din_v[0]),
        .grant(grant_v[0]), .busy(busy_v[0])
    );

    uart_tx_arbiter #(.DATA_WIDTH(8), .BURST_LEN(1)) dut_b (
        .clk(clk), .reset(reset), .en(en_v[1]),
        .empty0(empty0_v[1]), .r_data0(r_data0_v[1]), .rd0(rd0_v[1]),
        .empty1(empty1_v[1]), .r_data1(r_data1_v[1]), .rd1(rd1_v[1]),
        .tx_done_tick(tx_done_v[1]), .tx_start(tx_start_v[1]), .tx_din(tx_din_v[1]),
        .grant(grant_v[1]), .busy(busy_v[1])
    );

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            empty0_v[i]  = !(p0[i] < n0[i]);
            empty1_v[i]  = !(p1[i] < n1[i]);
            r_data0_v[i] = mem0[i][p0[i][3:0]];
            r_data1_v[i] = mem1[i][p1[i][3:0]];
            tx_done_v[i] = (tmr[i] == 1) || stray_v[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (fifo_clr) begin
                p0[i] <= 0;
                p1[i] <= 0;
            end else begin
                if (rd0_v[i]) p0[i] <= p0[i] + 1;
                if (rd1_v[i]) p1[i] <= p1[i] + 1;
            end
        end
    end

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) tmr[i] <= 0;
            else if (tx_start_v[i]) tmr[i] <= DLY;
            else if (tmr[i] != 0) tmr[i] <= tmr[i] - 1;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (tx_done_v[i]) last_done[i] <= cyc;
            if (tx_start_v[i] && log_n[i] < LOGN) begin
                log_din[i][log_n[i]]   <= tx_din_v[i];
                log_grant[i][log_n[i]] <= grant_v[i];
                log_rd0[i][log_n[i]]   <= rd0_v[i];
                log_rd1[i][log_n[i]]   <= rd1_v[i];
                log_gap[i][log_n[i]]   <= cyc - last_done[i];
                log_cyc[i][log_n[i]]   <= cyc;
                log_n[i]               <= log_n[i] + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_log(input int i, input int target, input int budget, input string tag);
        int k = 0;
        while (log_n[i] < target && k < budget) begin
            step(1);
            k++;
        end
        check(tag, 32'(log_n[i] >= target), 32'd1);
    endtask

    task automatic wait_idle(input int i, input int budget, input string tag);
        int k = 0;
        while (busy_v[i] !== 1'b0 && k < budget) begin
            step(1);
            k++;
        end
        check(tag, 32'(busy_v[i]), 32'd0);
    endtask

    task automatic clear_fifos();
        for (int i = 0; i < 2; i++) begin
            n0[i] = 0;
            n1[i] = 0;
        end
        fifo_clr = 1'b1;
        step(1);
        fifo_clr = 1'b0;
    endtask

    initial begin
        int base_a;
        int base_b;
        int k_cyc;
        for (int i = 0; i < 2; i++) begin
            en_v[i] = 1'b1;
            stray_v[i] = 1'b0;
            n0[i] = 0;
            n1[i] = 0;
        end
        mem0[0][0] = 8'h5A;
        mem1[0][0] = 8'hC3;

        // Reset and idle with both FIFOs empty
        step(1);
        check("rst_outs", {31'd0, busy_v[0]} | {31'd0, tx_start_v[0]} | {31'd0, rd0_v[0]} | {31'd0, rd1_v[0]}, 32'd0);
        check("rst_din", 32'(tx_din_v[0]), 32'h5A);
        step(2);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            check("idle_outs", {27'd0, tx_start_v[0], rd0_v[0], rd1_v[0], busy_v[0], grant_v[0]}, 32'd0);
            step(1);
        end

        // Single channel: three bytes from channel 0
        mem0[0][0] = 8'h41; mem0[0][1] = 8'h42; mem0[0][2] = 8'h43;
        base_a = log_n[0];
        k_cyc = cyc;
        n0[0] = 3;
        wait_log(0, base_a + 3, 100, "single_timeout");
        wait_idle(0, 40, "single_idle");
        check("single_latency", 32'(log_cyc[0][base_a] - k_cyc), 32'd1);
        for (int k = 0; k < 3; k++) begin
            check("single_din", 32'(log_din[0][base_a + k]), 32'h41 + 32'(k));
            check("single_rd0", {30'd0, log_rd0[0][base_a + k], log_rd1[0][base_a + k]}, 32'd2);
            if (k > 0) check("single_gap", 32'(log_gap[0][base_a + k]), 32'd1);
        end
        check("single_pops", 32'(p0[0]), 32'd3);
        check("single_grant", 32'(grant_v[0]), 32'd0);

        // Contention: both FIFOs loaded while reset is held
        reset = 1'b1;
        clear_fifos();
        for (int k = 0; k < 6; k++) mem0[0][k] = 8'(k);
        for (int k = 0; k < 3; k++) mem1[0][k] = 8'hA0 + 8'(k);
        for (int k = 0; k < 4; k++) begin
            mem0[1][k] = 8'(k);
            mem1[1][k] = 8'hA0 + 8'(k);
        end
        n0[0] = 6; n1[0] = 3; n0[1] = 4; n1[1] = 4;
        base_a = log_n[0];
        base_b = log_n[1];
        step(2);
        reset = 1'b0;
        wait_log(0, base_a + 9, 300, "burst4_timeout");
        wait_log(1, base_b + 8, 300, "burst1_timeout");
        wait_idle(0, 40, "burst4_idle");
        wait_idle(1, 40, "burst1_idle");
        for (int k = 0; k < 9; k++) begin
            check("burst4_order", 32'(log_din[0][base_a + k]), 32'(exp_a[k]));
            check("burst4_grant", 32'(log_grant[0][base_a + k]), 32'(exp_ga[k]));
            if (k > 0) check("burst4_gap", 32'(log_gap[0][base_a + k]), 32'd1);
        end
        for (int k = 0; k < 8; k++) begin
            check("burst1_order", 32'(log_din[1][base_b + k]), 32'(exp_b[k]));
        end

        // Enable control
        clear_fifos();
        mem0[0][0] = 8'h10; mem0[0][1] = 8'h11; mem0[0][2] = 8'h12;
        base_a = log_n[0];
        n0[0] = 3;
        wait_log(0, base_a + 1, 20, "en_first");
        step(3);
        en_v[0] = 1'b0;
        step(20);
        check("en_off_starts", 32'(log_n[0] - base_a), 32'd1);
        check("en_off_busy", 32'(busy_v[0]), 32'd0);
        check("en_off_pops", 32'(p0[0]), 32'd1);
        k_cyc = cyc;
        en_v[0] = 1'b1;
        wait_log(0, base_a + 2, 20, "en_resume");
        check("en_resume_lat", 32'(log_cyc[0][base_a + 1] - k_cyc), 32'd1);
        check("en_resume_din", 32'(log_din[0][base_a + 1]), 32'h11);
        wait_log(0, base_a + 3, 40, "en_drain");
        wait_idle(0, 40, "en_idle");

        // Stray done tick while idle
        base_a = log_n[0];
        stray_v[0] = 1'b1;
        step(1);
        stray_v[0] = 1'b0;
        step(5);
        check("stray_busy", 32'(busy_v[0]), 32'd0);
        check("stray_grant", 32'(grant_v[0]), 32'd0);
        check("stray_starts", 32'(log_n[0] - base_a), 32'd0);

        // Reset during WAIT, then channel 0 wins the tie
        clear_fifos();
        mem0[0][0] = 8'hC0;
        mem1[0][0] = 8'hB0; mem1[0][1] = 8'hB1;
        n1[0] = 2;
        wait_log(0, base_a + 1, 20, "abort_first");
        check("abort_first_grant", 32'(log_grant[0][base_a]), 32'd1);
        step(3);
        reset = 1'b1;
        #1;
        check("abort_outs", {28'd0, busy_v[0], tx_start_v[0], rd1_v[0], grant_v[0]}, 32'd0);
        n0[0] = 1;
        step(2);
        check("abort_held_pops", 32'(p1[0]), 32'd1);
        reset = 1'b0;
        wait_log(0, base_a + 3, 60, "abort_resume");
        check("abort_prio_din", 32'(log_din[0][base_a + 1]), 32'hC0);
        check("abort_prio_grant", 32'(log_grant[0][base_a + 1]), 32'd0);
        check("abort_next_din", 32'(log_din[0][base_a + 2]), 32'hB1);
        wait_idle(0, 40, "abort_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
